wb_demux_32: RTL and testbench

Write-back result router for the microprocessor datapath: the steering counterpart of the 32-bit 2:1 operand mux. It accepts one 32-bit word per cycle on a valid/ready input channel and delivers it to one of two destination channels, selected per word by `in_sel`. Each destination has a one-entry output register, so a stalled destination never blocks traffic to the other. It sits between the ALU result stage and its two consumers: register-file write port and memory store-data path.

---
 rtl/wb_demux_32.sv | 136 +++++++++++++
 tb/tb_wb_demux_32.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_demux_32.sv
// wb_demux_32 -- write-back result router.
//
// Steers one WIDTH-bit word per cycle from a valid/ready input channel to
// one of two destination channels (register-file write port / store-data
// path), chosen per word by in_sel. Each destination owns a one-entry
// output register, so a stalled destination never blocks the other one.
//
// Optional feature macro: WB_DEMUX_CNT_EN
//   defined     -> cnt0/cnt1 ports present, counting deliveries per
//                  destination (wrap at 2^CNT_W, cleared only by rst)
//   undefined   -> no counter ports or logic
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous, active-high reset
//   in_valid/in_ready    input handshake
//   in_sel               destination select (0 -> out0, 1 -> out1)
//   in_data              input word
//   outN_valid/outN_ready destination N handshake
//   outN_data            buffered word for destination N
//   cnt0/cnt1            delivery counters (WB_DEMUX_CNT_EN only)
module wb_demux_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef WB_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("wb_demux_32: WIDTH and CNT_W must be positive");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_st_t;

  buf_st_t          st0_p0, st1_p0;
  buf_st_t          st0_nxt, st1_nxt;
  logic [WIDTH-1:0] data0_p0, data1_p0;
  logic             acc0, acc1;
  logic             dlv0, dlv1;

  // Handshake decode. in_ready looks only at the selected destination so a
  // stalled buffer cannot hold off words bound for the other one.
  always_comb begin
    in_ready = in_sel ? (!out1_valid || out1_ready)
                      : (!out0_valid || out0_ready);
    acc0     = in_valid && in_ready && !in_sel;
    acc1     = in_valid && in_ready &&  in_sel;
    dlv0     = out0_valid && out0_ready;
    dlv1     = out1_valid && out1_ready;
  end

  // Buffer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0_p0 <= EMPTY;
      st1_p0 <= EMPTY;
    end else begin
      st0_p0 <= st0_nxt;
      st1_p0 <= st1_nxt;
    end
  end

  // Next-state: a full buffer that delivers and is refilled in the same
  // cycle stays FULL, giving bubble-free streaming.
  always_comb begin
    st0_nxt = st0_p0;
    st1_nxt = st1_p0;
    case (st0_p0)
      EMPTY:   if (acc0)         st0_nxt = FULL;
      FULL:    if (dlv0 && !acc0) st0_nxt = EMPTY;
      default: st0_nxt = EMPTY;
    endcase
    case (st1_p0)
      EMPTY:   if (acc1)         st1_nxt = FULL;
      FULL:    if (dlv1 && !acc1) st1_nxt = EMPTY;
      default: st1_nxt = EMPTY;
    endcase
  end

  // Outputs from buffer state
  always_comb begin
    out0_valid = (st0_p0 == FULL);
    out1_valid = (st1_p0 == FULL);
    out0_data  = data0_p0;
    out1_data  = data1_p0;
  end

  // Data registers: only an accept to that destination changes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_p0 <= '0;
      data1_p0 <= '0;
    end else begin
      if (acc0) data0_p0 <= in_data;
      if (acc1) data1_p0 <= in_data;
    end
  end

`ifdef WB_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_p0, cnt1_p0;

  // Delivery counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_p0 <= '0;
      cnt1_p0 <= '0;
    end else begin
      if (dlv0) cnt0_p0 <= cnt0_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
      if (dlv1) cnt1_p0 <= cnt1_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt0 = cnt0_p0;
  assign cnt1 = cnt1_p0;
`endif

endmodule

// File: tb/tb_wb_demux_32.sv
module tb_wb_demux_32;

  localparam int W    = 32;
  localparam int TCW  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_sel;
  logic [W-1:0] in_data;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0] out0_data, out1_data;

  always #5 clk = ~clk;

`ifdef WB_DEMUX_CNT_EN
  logic [TCW-1:0] cnt0, cnt1;
  wb_demux_32 #(.WIDTH(W), .CNT_W(TCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );
`else
  wb_demux_32 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
  );
`endif

  // Scoreboard: one queue per destination; a one-entry buffer means each
  // queue holds at most one word, and its head is what must be on the output.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int total = 0;
  int bad   = 0;
  int mc0   = 0;
  int mc1   = 0;
  int ndlv  = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, check just after, update the
  // model at the posedge, return at the next negedge.
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1, output logic acc);
    logic er, d0, d1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    er = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    chk("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
    chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
`ifdef WB_DEMUX_CNT_EN
    chk("cnt0", {28'b0, cnt0}, 32'(mc0 % (1 << TCW)));
    chk("cnt1", {28'b0, cnt1}, 32'(mc1 % (1 << TCW)));
`endif
    d0  = (q0.size() != 0) && r0;
    d1  = (q1.size() != 0) && r1;
    acc = v && er;
    @(posedge clk);
    if (d0) begin void'(q0.pop_front()); mc0++; ndlv++; end
    if (d1) begin void'(q1.pop_front()); mc1++; ndlv++; end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    in_sel = 1'b0;
    #0;
    chk({tag, "_ready0"}, {31'b0, in_ready}, 32'd1);
    in_sel = 1'b1;
    #0;
    chk({tag, "_ready1"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_v0"}, {31'b0, out0_valid}, 32'd0);
    chk({tag, "_v1"}, {31'b0, out1_valid}, 32'd0);
    chk({tag, "_d0"}, out0_data, 32'd0);
    chk({tag, "_d1"}, out1_data, 32'd0);
`ifdef WB_DEMUX_CNT_EN
    chk({tag, "_c0"}, {28'b0, cnt0}, 32'd0);
    chk({tag, "_c1"}, {28'b0, cnt1}, 32'd0);
`endif
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    mc0 = 0;
    mc1 = 0;
  endtask

  initial begin
    logic acc;
    int   tries;
    int   n_start;

    in_valid = 0; in_sel = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
    rst = 1'b1;
    #1;
    check_reset_state("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Routing: 40 -> out0, 50 -> out1, each visible for one cycle
    cycle(1, 0, 32'd40, 1, 1, acc);
    cycle(1, 1, 32'd50, 1, 1, acc);
    cycle(0, 0, 32'd0,  1, 1, acc);
    cycle(0, 0, 32'd0,  1, 1, acc);

    // Backpressure on out0: 41 waits while 40 is held, then swaps in
    cycle(1, 0, 32'd40, 0, 0, acc);
    cycle(1, 0, 32'd41, 0, 0, acc);
    chk("bp_stall", {31'b0, acc}, 32'd0);
    cycle(1, 0, 32'd41, 0, 0, acc);
    cycle(1, 0, 32'd41, 1, 0, acc);
    chk("bp_swap", {31'b0, acc}, 32'd1);

    // Isolation: out0 stays stalled with 41 while out1 streams 50..52
    cycle(1, 1, 32'd50, 0, 1, acc);
    cycle(1, 1, 32'd51, 0, 1, acc);
    cycle(1, 1, 32'd52, 0, 1, acc);
    cycle(0, 1, 32'd0,  0, 1, acc);
    cycle(0, 1, 32'd0,  0, 1, acc);
    chk("iso_hold", out0_data, 32'd41);

    // Reset mid-cycle with both buffers full
    cycle(1, 1, 32'd77, 0, 0, acc);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    clear_model();
    @(negedge clk);
    rst = 1'b0;

`ifdef WB_DEMUX_CNT_EN
    // Counter wrap: 17 deliveries on out1 with a 4-bit counter
    for (int i = 0; i < 17; i++) cycle(1, 1, 32'(200 + i), 1, 1, acc);
    cycle(0, 0, 32'd0, 1, 1, acc);
    chk("cnt1_wrap", {28'b0, cnt1}, 32'd1);
    chk("cnt0_idle", {28'b0, cnt0}, 32'd0);
`endif

    // Streaming: 100 words, alternating destinations, random readys
    n_start = ndlv;
    for (int i = 0; i < 100; i++) begin
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        cycle(1, i[0], 32'h1000 + 32'(i), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), acc);
        tries++;
      end
      chk("stream_accept", {31'b0, acc}, 32'd1);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 32'd0, 1, 1, acc);
    chk("stream_count", 32'(ndlv - n_start), 32'd100);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
